// File: rtl/ex_muldiv_stage.sv
// Execute stage: decode-to-execute pipe register, 12-op ALU, data SRAM request,
// HI/LO registers and an iterative 32-cycle divider. Optional macro EX_MUL_EN adds a single-cycle multiplier.
module ex_muldiv_stage #(
  parameter int ID_TO_EX_WD  = 159,
  parameter int EX_TO_MEM_WD = 76,
  parameter int EX_TO_RF_WD  = 38
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              stall,
  output logic                    stallreq_for_ex,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
  output logic                    ex_is_load,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [ID_TO_EX_WD-1:0] pipe_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     pipe_q <= '0;
    else if (stall[2] && !stall[3]) pipe_q <= '0;
    else if (!stall[2])          pipe_q <= id_to_ex_bus;
  end

  logic [31:0] pc, inst, rs_data, rt_data;
  logic [11:0] alu_op;
  logic [2:0]  src1;
  logic [3:0]  src2;
  logic [3:0]  ram_wen;
  logic [4:0]  rf_waddr;
  logic        ram_en, rf_we, sel_rf_res;

  assign pc         = pipe_q[158:127];
  assign inst       = pipe_q[126:95];
  assign alu_op     = pipe_q[94:83];
  assign src1       = pipe_q[82:80];
  assign src2       = pipe_q[79:76];
  assign ram_en     = pipe_q[75];
  assign ram_wen    = pipe_q[74:71];
  assign rf_we      = pipe_q[70];
  assign rf_waddr   = pipe_q[69:65];
  assign sel_rf_res = pipe_q[64];
  assign rs_data    = pipe_q[63:32];
  assign rt_data    = pipe_q[31:0];

  // ALU operand muxes and one-hot result merge
  logic [31:0] op_a, op_b, alu_res;

  assign op_a = ({32{src1[0]}} & rs_data)
              | ({32{src1[1]}} & pc)
              | ({32{src1[2]}} & {27'b0, inst[10:6]});
  assign op_b = ({32{src2[0]}} & rt_data)
              | ({32{src2[1]}} & {{16{inst[15]}}, inst[15:0]})
              | ({32{src2[2]}} & 32'd8)
              | ({32{src2[3]}} & {16'b0, inst[15:0]});

  always_comb begin
    alu_res = '0;
    if (alu_op[11]) alu_res = alu_res | (op_a + op_b);
    if (alu_op[10]) alu_res = alu_res | (op_a - op_b);
    if (alu_op[9])  alu_res = alu_res | {31'b0, $signed(op_a) < $signed(op_b)};
    if (alu_op[8])  alu_res = alu_res | {31'b0, op_a < op_b};
    if (alu_op[7])  alu_res = alu_res | (op_a & op_b);
    if (alu_op[6])  alu_res = alu_res | ~(op_a | op_b);
    if (alu_op[5])  alu_res = alu_res | (op_a | op_b);
    if (alu_op[4])  alu_res = alu_res | (op_a ^ op_b);
    if (alu_op[3])  alu_res = alu_res | (op_b << op_a[4:0]);
    if (alu_op[2])  alu_res = alu_res | (op_b >> op_a[4:0]);
    if (alu_op[1])  alu_res = alu_res | 32'($signed(op_b) >>> op_a[4:0]);
    if (alu_op[0])  alu_res = alu_res | {op_b[15:0], 16'b0};
  end

  logic       is_r;
  logic [5:0] funct;
  logic       is_mfhi, is_mthi, is_mflo, is_mtlo, is_div, div_sgn;

  assign is_r    = (inst[31:26] == 6'd0);
  assign funct   = inst[5:0];
  assign is_mfhi = is_r && (funct == 6'h10);
  assign is_mthi = is_r && (funct == 6'h11);
  assign is_mflo = is_r && (funct == 6'h12);
  assign is_mtlo = is_r && (funct == 6'h13);
  assign div_sgn = is_r && (funct == 6'h1A);
  assign is_div  = div_sgn || (is_r && (funct == 6'h1B));

`ifdef EX_MUL_EN
  logic        is_mult;
  logic [63:0] prod;
  assign is_mult = is_r && ((funct == 6'h18) || (funct == 6'h19));
  assign prod = (funct == 6'h18)
              ? 64'($signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data}))
              : ({32'b0, rs_data} * {32'b0, rt_data});
`endif

  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [1:0]  st_q, st_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d;
  logic        qneg_q, qneg_d, rneg_q, rneg_d;

  // Restoring step: shift the next dividend bit into the partial remainder, subtract if it fits
  logic [32:0] rem_sh, diff;
  logic [31:0] rem_nx, quo_nx, dvd_abs, dsr_abs;

  assign rem_sh  = {rem_q, quo_q[31]};
  assign diff    = rem_sh - {1'b0, dsr_q};
  assign rem_nx  = diff[32] ? rem_sh[31:0] : diff[31:0];
  assign quo_nx  = {quo_q[30:0], ~diff[32]};
  assign dvd_abs = (div_sgn && rs_data[31]) ? -rs_data : rs_data;
  assign dsr_abs = (div_sgn && rt_data[31]) ? -rt_data : rt_data;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dsr_d  = dsr_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (!stall[2]) begin
      if (is_mthi) hi_d = rs_data;
      if (is_mtlo) lo_d = rs_data;
`ifdef EX_MUL_EN
      if (is_mult) {hi_d, lo_d} = prod;
`endif
    end
    case (st_q)
      S_IDLE: if (is_div) begin
        if (rt_data == 32'd0) begin
          st_d = S_DONE;
          lo_d = 32'hFFFF_FFFF;
          hi_d = rs_data;
        end else begin
          st_d   = S_RUN;
          cnt_d  = 5'd0;
          rem_d  = 32'd0;
          quo_d  = dvd_abs;
          dsr_d  = dsr_abs;
          qneg_d = div_sgn && (rs_data[31] ^ rt_data[31]);
          rneg_d = div_sgn && rs_data[31];
        end
      end
      S_RUN: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          st_d = S_DONE;
          lo_d = qneg_q ? -quo_nx : quo_nx;
          hi_d = rneg_q ? -rem_nx : rem_nx;
        end
      end
      // Wait here until EX advances so a held divide is not restarted
      S_DONE: if (!stall[2]) st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= S_IDLE;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dsr_q  <= dsr_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign stallreq_for_ex = ((st_q == S_IDLE) && is_div) || (st_q == S_RUN);

  logic [31:0] ex_result;
  assign ex_result = is_mfhi ? hi_q : (is_mflo ? lo_q : alu_res);

  assign ex_to_mem_bus   = {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result};
  assign ex_to_rf_bus    = {rf_we, rf_waddr, ex_result};
  assign ex_is_load      = sel_rf_res;
  assign data_sram_en    = ram_en;
  assign data_sram_wen   = ram_wen[0] ? 4'b1111 : 4'b0000;
  assign data_sram_addr  = ex_result;
  assign data_sram_wdata = rt_data;

  logic unused_ok;
  assign unused_ok = ^{stall[5:4], stall[1:0], inst[25:16], ram_wen[3:1]};

endmodule
